stack_interface_elastic: RTL and testbench

Parametrised successor of the PE stack-bus interface. It sits between the stack bus and the PE: downstream lane streams go to the streaming ops, downstream OOB goes to the PE control, and upstream SIMD traffic goes back to the stack bus.
- Every path is a true valid/ready elastic FIFO of configurable depth, so ready is never simply registered.
- Adds per-channel SOP/EOP framing checking with sticky error reporting.

---
 rtl/stack_interface_elastic.sv | 236 +++++++++++++++++++++++
 tb/tb_stack_interface_elastic.sv | 343 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/stack_interface_elastic.sv
`default_nettype none
// ============================================================================
// Module : stack_interface_elastic (+ stack_interface_elastic_fifo)
// Desc   : Elastic valid/ready FIFOs with SOP/EOP framing checks between the
//          stack bus, the streaming ops, PE control and upstream SIMD.
// Rev    : 1.0
// ============================================================================

module stack_interface_elastic_fifo #(
  parameter int DEPTH  = 4,
  parameter int WIDTH  = 34,
  parameter int CNTL_W = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             err_clr,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready,
  output logic             frame_err
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  localparam logic [1:0] CNTL_MOP = 2'b00;
  localparam logic [1:0] CNTL_SOP = 2'b01;
  localparam logic [1:0] CNTL_SOM = 2'b11;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W-1:0] r_wr_ptr;
  logic [CNT_W-1:0] r_count;
  logic             r_in_pkt;
  logic             r_err;

  logic             w_push;
  logic             w_pop;
  logic [1:0]       w_cntl;
  logic             w_start;
  logic             w_bad;

  // Cntl occupies the top bits of every stored word.
  assign w_cntl    = in_data[WIDTH-CNTL_W +: 2];
  assign w_start   = (w_cntl == CNTL_SOP) || (w_cntl == CNTL_SOM);
  assign w_bad     = w_start ? r_in_pkt : !r_in_pkt;

  assign in_ready  = (r_count != CNT_W'(DEPTH));
  assign out_valid = (r_count != '0);
  assign out_data  = r_mem[r_rd_ptr];
  assign frame_err = r_err;

  assign w_push    = in_valid && in_ready;
  assign w_pop     = out_valid && out_ready;

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= in_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
      r_in_pkt <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
        // SOP/MOP leave the channel inside a packet, EOP/SOM outside.
        r_in_pkt <= (w_cntl == CNTL_SOP) || (w_cntl == CNTL_MOP);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
      if (w_push && w_bad) begin
        r_err <= 1'b1;
      end else if (err_clr) begin
        r_err <= 1'b0;
      end
    end
  end

endmodule

module stack_interface_elastic #(
  parameter int NUM_LANES   = 32,
  parameter int NUM_STREAMS = 2,
  parameter int STRM_DATA_W = 32,
  parameter int CNTL_W      = 2,
  parameter int DEPTH       = 4,
  parameter int OOB_TYPE_W  = 2,
  parameter int OOB_DATA_W  = 32,
  parameter int OOB_DEPTH   = 2,
  parameter int UP_TYPE_W   = 2,
  parameter int UP_DATA_W   = 64,
  parameter int UP_OOB_W    = 32,
  parameter int UP_DEPTH    = 4,
  parameter int NCH         = NUM_LANES * NUM_STREAMS
) (
  input  logic                        clk,
  input  logic                        reset_poweron,

  input  logic [NCH-1:0]              std__pe__lane_strm_valid,
  input  logic [NCH*CNTL_W-1:0]       std__pe__lane_strm_cntl,
  input  logic [NCH*STRM_DATA_W-1:0]  std__pe__lane_strm_data,
  output logic [NCH-1:0]              pe__std__lane_strm_ready,

  output logic [NCH-1:0]              sti__stOp__lane_strm_valid,
  output logic [NCH*CNTL_W-1:0]       sti__stOp__lane_strm_cntl,
  output logic [NCH*STRM_DATA_W-1:0]  sti__stOp__lane_strm_data,
  input  logic [NCH-1:0]              stOp__sti__lane_strm_ready,

  input  logic                        std__pe__oob_valid,
  input  logic [CNTL_W-1:0]           std__pe__oob_cntl,
  input  logic [OOB_TYPE_W-1:0]       std__pe__oob_type,
  input  logic [OOB_DATA_W-1:0]       std__pe__oob_data,
  output logic                        pe__std__oob_ready,

  output logic                        sti__cntl__oob_valid,
  output logic [CNTL_W-1:0]           sti__cntl__oob_cntl,
  output logic [OOB_TYPE_W-1:0]       sti__cntl__oob_type,
  output logic [OOB_DATA_W-1:0]       sti__cntl__oob_data,
  input  logic                        cntl__sti__oob_ready,

  input  logic                        sui__sti__valid,
  input  logic [CNTL_W-1:0]           sui__sti__cntl,
  input  logic [UP_TYPE_W-1:0]        sui__sti__type,
  input  logic [UP_DATA_W-1:0]        sui__sti__data,
  input  logic [UP_OOB_W-1:0]         sui__sti__oob_data,
  output logic                        sti__sui__ready,

  output logic                        pe__stu__valid,
  output logic [CNTL_W-1:0]           pe__stu__cntl,
  output logic [UP_TYPE_W-1:0]        pe__stu__type,
  output logic [UP_DATA_W-1:0]        pe__stu__data,
  output logic [UP_OOB_W-1:0]         pe__stu__oob_data,
  input  logic                        stu__pe__ready,

  input  logic                        err_clr,
  output logic [NCH-1:0]              lane_frame_err,
  output logic                        oob_frame_err,
  output logic                        up_frame_err
);

  localparam int LANE_W = CNTL_W + STRM_DATA_W;
  localparam int OOB_W  = CNTL_W + OOB_TYPE_W + OOB_DATA_W;
  localparam int UP_W   = CNTL_W + UP_TYPE_W + UP_DATA_W + UP_OOB_W;

  genvar ch;
  generate
    for (ch = 0; ch < NCH; ch++) begin : g_lane
      logic [LANE_W-1:0] w_in;
      logic [LANE_W-1:0] w_out;

      assign w_in = {std__pe__lane_strm_cntl[ch*CNTL_W +: CNTL_W],
                     std__pe__lane_strm_data[ch*STRM_DATA_W +: STRM_DATA_W]};
      assign sti__stOp__lane_strm_cntl[ch*CNTL_W +: CNTL_W] =
        w_out[LANE_W-1 -: CNTL_W];
      assign sti__stOp__lane_strm_data[ch*STRM_DATA_W +: STRM_DATA_W] =
        w_out[STRM_DATA_W-1:0];

      stack_interface_elastic_fifo #(
        .DEPTH  (DEPTH),
        .WIDTH  (LANE_W),
        .CNTL_W (CNTL_W)
      ) u_lane_fifo (
        .clk       (clk),
        .rst_n     (reset_poweron),
        .err_clr   (err_clr),
        .in_valid  (std__pe__lane_strm_valid[ch]),
        .in_data   (w_in),
        .in_ready  (pe__std__lane_strm_ready[ch]),
        .out_valid (sti__stOp__lane_strm_valid[ch]),
        .out_data  (w_out),
        .out_ready (stOp__sti__lane_strm_ready[ch]),
        .frame_err (lane_frame_err[ch])
      );
    end
  endgenerate

  logic [OOB_W-1:0] w_oob_out;

  assign {sti__cntl__oob_cntl, sti__cntl__oob_type, sti__cntl__oob_data} = w_oob_out;

  stack_interface_elastic_fifo #(
    .DEPTH  (OOB_DEPTH),
    .WIDTH  (OOB_W),
    .CNTL_W (CNTL_W)
  ) u_oob_fifo (
    .clk       (clk),
    .rst_n     (reset_poweron),
    .err_clr   (err_clr),
    .in_valid  (std__pe__oob_valid),
    .in_data   ({std__pe__oob_cntl, std__pe__oob_type, std__pe__oob_data}),
    .in_ready  (pe__std__oob_ready),
    .out_valid (sti__cntl__oob_valid),
    .out_data  (w_oob_out),
    .out_ready (cntl__sti__oob_ready),
    .frame_err (oob_frame_err)
  );

  logic [UP_W-1:0] w_up_out;

  assign {pe__stu__cntl, pe__stu__type, pe__stu__data, pe__stu__oob_data} = w_up_out;

  stack_interface_elastic_fifo #(
    .DEPTH  (UP_DEPTH),
    .WIDTH  (UP_W),
    .CNTL_W (CNTL_W)
  ) u_up_fifo (
    .clk       (clk),
    .rst_n     (reset_poweron),
    .err_clr   (err_clr),
    .in_valid  (sui__sti__valid),
    .in_data   ({sui__sti__cntl, sui__sti__type, sui__sti__data, sui__sti__oob_data}),
    .in_ready  (sti__sui__ready),
    .out_valid (pe__stu__valid),
    .out_data  (w_up_out),
    .out_ready (stu__pe__ready),
    .frame_err (up_frame_err)
  );

endmodule

`default_nettype wire

// File: tb/tb_stack_interface_elastic.sv
`default_nettype none
// ============================================================================
// Module : tb_stack_interface_elastic
// Desc   : Scoreboard bench for the elastic stack interface.
// Rev    : 1.0
// ============================================================================
module tb_stack_interface_elastic;

  localparam int NCH  = 64;
  localparam int CW   = 2;
  localparam int DW   = 32;
  localparam int OTW  = 2;
  localparam int ODW  = 32;
  localparam int UTW  = 2;
  localparam int UDW  = 64;
  localparam int UOW  = 32;
  localparam int LANE_W = CW + DW;
  localparam int OOB_W  = CW + OTW + ODW;
  localparam int UP_W   = CW + UTW + UDW + UOW;

  localparam logic [1:0] MOP = 2'b00;
  localparam logic [1:0] SOP = 2'b01;
  localparam logic [1:0] EOP = 2'b10;
  localparam logic [1:0] SOM = 2'b11;
  localparam logic [NCH-1:0] ALL1 = '1;

  logic                clk;
  logic                reset_poweron;
  logic [NCH-1:0]      lane_valid;
  logic [NCH*CW-1:0]   lane_cntl;
  logic [NCH*DW-1:0]   lane_data;
  logic [NCH-1:0]      lane_ready;
  logic [NCH-1:0]      stop_valid;
  logic [NCH*CW-1:0]   stop_cntl;
  logic [NCH*DW-1:0]   stop_data;
  logic [NCH-1:0]      stop_ready;
  logic                oob_valid;
  logic [CW-1:0]       oob_cntl;
  logic [OTW-1:0]      oob_type;
  logic [ODW-1:0]      oob_data;
  logic                oob_ready;
  logic                co_valid;
  logic [CW-1:0]       co_cntl;
  logic [OTW-1:0]      co_type;
  logic [ODW-1:0]      co_data;
  logic                co_ready;
  logic                up_valid;
  logic [CW-1:0]       up_cntl;
  logic [UTW-1:0]      up_type;
  logic [UDW-1:0]      up_data;
  logic [UOW-1:0]      up_oob;
  logic                up_ready;
  logic                pu_valid;
  logic [CW-1:0]       pu_cntl;
  logic [UTW-1:0]      pu_type;
  logic [UDW-1:0]      pu_data;
  logic [UOW-1:0]      pu_oob;
  logic                stu_ready;
  logic                err_clr;
  logic [NCH-1:0]      lane_err;
  logic                oob_err;
  logic                up_err;

  int n_checks = 0;
  int n_errors = 0;
  int acc_cnt [NCH];

  logic [LANE_W-1:0] lane_q [NCH][$];
  logic [OOB_W-1:0]  oob_q [$];
  logic [UP_W-1:0]   up_q [$];

  stack_interface_elastic dut (
    .clk                        (clk),
    .reset_poweron              (reset_poweron),
    .std__pe__lane_strm_valid   (lane_valid),
    .std__pe__lane_strm_cntl    (lane_cntl),
    .std__pe__lane_strm_data    (lane_data),
    .pe__std__lane_strm_ready   (lane_ready),
    .sti__stOp__lane_strm_valid (stop_valid),
    .sti__stOp__lane_strm_cntl  (stop_cntl),
    .sti__stOp__lane_strm_data  (stop_data),
    .stOp__sti__lane_strm_ready (stop_ready),
    .std__pe__oob_valid         (oob_valid),
    .std__pe__oob_cntl          (oob_cntl),
    .std__pe__oob_type          (oob_type),
    .std__pe__oob_data          (oob_data),
    .pe__std__oob_ready         (oob_ready),
    .sti__cntl__oob_valid       (co_valid),
    .sti__cntl__oob_cntl        (co_cntl),
    .sti__cntl__oob_type        (co_type),
    .sti__cntl__oob_data        (co_data),
    .cntl__sti__oob_ready       (co_ready),
    .sui__sti__valid            (up_valid),
    .sui__sti__cntl             (up_cntl),
    .sui__sti__type             (up_type),
    .sui__sti__data             (up_data),
    .sui__sti__oob_data         (up_oob),
    .sti__sui__ready            (up_ready),
    .pe__stu__valid             (pu_valid),
    .pe__stu__cntl              (pu_cntl),
    .pe__stu__type              (pu_type),
    .pe__stu__data              (pu_data),
    .pe__stu__oob_data          (pu_oob),
    .stu__pe__ready             (stu_ready),
    .err_clr                    (err_clr),
    .lane_frame_err             (lane_err),
    .oob_frame_err              (oob_err),
    .up_frame_err               (up_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: record accepted input beats, compare every output handshake.
  always @(negedge clk) begin
    if (!reset_poweron) begin
      for (int c = 0; c < NCH; c++) lane_q[c].delete();
      oob_q.delete();
      up_q.delete();
    end else begin
      for (int c = 0; c < NCH; c++) begin
        if (stop_valid[c] && stop_ready[c]) begin
          if (lane_q[c].size() == 0) check("lane_underflow", 1, 0);
          else check("lane_data", {stop_cntl[c*CW +: CW], stop_data[c*DW +: DW]},
                     lane_q[c].pop_front());
        end
        if (lane_valid[c] && lane_ready[c]) begin
          lane_q[c].push_back({lane_cntl[c*CW +: CW], lane_data[c*DW +: DW]});
          acc_cnt[c]++;
        end
      end
      if (co_valid && co_ready) begin
        if (oob_q.size() == 0) check("oob_underflow", 1, 0);
        else check("oob_data", {co_cntl, co_type, co_data}, oob_q.pop_front());
      end
      if (oob_valid && oob_ready) oob_q.push_back({oob_cntl, oob_type, oob_data});
      if (pu_valid && stu_ready) begin
        if (up_q.size() == 0) check("up_underflow", 1, 0);
        else check("up_data", {pu_cntl, pu_type, pu_data, pu_oob}, up_q.pop_front());
      end
      if (up_valid && up_ready) up_q.push_back({up_cntl, up_type, up_data, up_oob});
    end
  end

  // Each send task starts just after a rising edge and returns just after
  // the edge on which the beat was accepted.
  task automatic send_lane(input int ch, input logic [1:0] c, input logic [31:0] d);
    int n;
    n = 0;
    lane_valid[ch] = 1'b1;
    lane_cntl[ch*CW +: CW] = c;
    lane_data[ch*DW +: DW] = d;
    @(negedge clk);
    while (!lane_ready[ch] && n < 50) begin @(negedge clk); n++; end
    if (!lane_ready[ch]) check("lane_send_timeout", 0, 1);
    @(posedge clk); #1;
    lane_valid[ch] = 1'b0;
  endtask

  task automatic send_oob(input logic [1:0] c, input logic [31:0] d);
    int n;
    n = 0;
    oob_valid = 1'b1; oob_cntl = c; oob_type = d[1:0]; oob_data = d;
    @(negedge clk);
    while (!oob_ready && n < 50) begin @(negedge clk); n++; end
    if (!oob_ready) check("oob_send_timeout", 0, 1);
    @(posedge clk); #1;
    oob_valid = 1'b0;
  endtask

  task automatic send_up(input logic [1:0] c, input logic [63:0] d);
    int n;
    n = 0;
    up_valid = 1'b1; up_cntl = c; up_type = d[3:2]; up_data = d; up_oob = ~d[31:0];
    @(negedge clk);
    while (!up_ready && n < 50) begin @(negedge clk); n++; end
    if (!up_ready) check("up_send_timeout", 0, 1);
    @(posedge clk); #1;
    up_valid = 1'b0;
  endtask

  task automatic pulse_clr();
    err_clr = 1'b1;
    @(posedge clk); #1;
    err_clr = 1'b0;
  endtask

  initial begin
    lane_valid = '0; lane_cntl = '0; lane_data = '0; stop_ready = '1;
    oob_valid = 1'b0; oob_cntl = '0; oob_type = '0; oob_data = '0; co_ready = 1'b1;
    up_valid = 1'b0; up_cntl = '0; up_type = '0; up_data = '0; up_oob = '0; stu_ready = 1'b1;
    err_clr = 1'b0;
    for (int c = 0; c < NCH; c++) acc_cnt[c] = 0;
    reset_poweron = 1'b0;
    #2;
    check("rst_stop_valid", stop_valid, 0);
    check("rst_lane_ready", lane_ready, ALL1);
    check("rst_oob_valid", co_valid, 0);
    check("rst_oob_ready", oob_ready, 1);
    check("rst_up_valid", pu_valid, 0);
    check("rst_up_ready", up_ready, 1);
    check("rst_errs", {lane_err, oob_err, up_err}, 0);
    repeat (3) @(posedge clk);
    @(negedge clk) reset_poweron = 1'b1;
    @(posedge clk); #1;

    // Single beat: visible on the cycle after acceptance, only on ch0.
    check("single_pre_valid", stop_valid, 0);
    send_lane(0, SOM, 32'hA5A5_0001);
    check("single_valid", stop_valid, 64'h1);
    @(posedge clk); #1;
    check("single_drained", stop_valid, 0);

    // Fill/backpressure on ch3.
    stop_ready[3] = 1'b0;
    send_lane(3, SOP, 1);
    send_lane(3, MOP, 2);
    send_lane(3, MOP, 3);
    check("fill_ready_at3", lane_ready[3], 1);
    send_lane(3, MOP, 4);
    @(negedge clk);
    check("fill_ready_full", lane_ready[3], 0);
    check("fill_out_valid", stop_valid[3], 1);
    @(posedge clk); #1;
    stop_ready[3] = 1'b1;
    send_lane(3, MOP, 5);
    send_lane(3, EOP, 6);
    repeat (8) @(posedge clk); #1;
    check("fill_drained", lane_q[3].size(), 0);
    check("fill_valid_low", stop_valid[3], 0);

    // Simultaneous push+pop at count 3, then blocked push at count 4.
    stop_ready[3] = 1'b0;
    send_lane(3, SOP, 32'h11);
    send_lane(3, MOP, 32'h12);
    send_lane(3, MOP, 32'h13);
    stop_ready[3] = 1'b1;
    send_lane(3, MOP, 32'h14);
    stop_ready[3] = 1'b0;
    @(negedge clk);
    check("simul_count3_ready", lane_ready[3], 1);
    @(posedge clk); #1;
    send_lane(3, EOP, 32'h15);
    lane_valid[3] = 1'b1; lane_cntl[3*CW +: CW] = SOP; lane_data[3*DW +: DW] = 32'h99;
    @(negedge clk);
    check("full_block_ready0", lane_ready[3], 0);
    @(negedge clk);
    check("full_block_ready1", lane_ready[3], 0);
    @(posedge clk); #1;
    lane_valid[3] = 1'b0;
    stop_ready[3] = 1'b1;
    repeat (8) @(posedge clk); #1;
    check("simul_drained", lane_q[3].size(), 0);
    check("lane_err_clean", lane_err, 0);

    // Full throughput on every channel.
    for (int c = 0; c < NCH; c++) acc_cnt[c] = 0;
    lane_valid = '1;
    lane_cntl = {NCH{SOM}};
    for (int i = 0; i < 100; i++) begin
      for (int c = 0; c < NCH; c++) lane_data[c*DW +: DW] = $urandom;
      @(negedge clk);
      check("tput_ready", lane_ready, ALL1);
      if (i > 0) check("tput_valid", stop_valid, ALL1);
      @(posedge clk); #1;
    end
    lane_valid = '0;
    repeat (4) @(posedge clk); #1;
    for (int c = 0; c < NCH; c++) begin
      check("tput_count", acc_cnt[c], 100);
      check("tput_drained", lane_q[c].size(), 0);
    end

    // Lane framing: MOP outside a packet on ch5.
    send_lane(5, MOP, 32'h55);
    check("lane_err_set", lane_err, 64'h20);
    pulse_clr();
    check("lane_err_clr", lane_err, 0);

    // Upstream framing.
    send_up(SOP, 64'h1000_0000_0000_0001);
    check("up_err_sop", up_err, 0);
    send_up(SOP, 64'h1000_0000_0000_0002);
    check("up_err_2sop", up_err, 1);
    send_up(EOP, 64'h1000_0000_0000_0003);
    check("up_err_sticky", up_err, 1);
    pulse_clr();
    check("up_err_clr", up_err, 0);
    send_up(MOP, 64'h1000_0000_0000_0004);
    check("up_err_mop", up_err, 1);
    pulse_clr();
    check("up_err_clr2", up_err, 0);
    err_clr = 1'b1;
    send_up(SOP, 64'h1000_0000_0000_0005);
    err_clr = 1'b0;
    check("up_err_set_wins", up_err, 1);
    send_up(EOP, 64'h1000_0000_0000_0006);
    repeat (6) @(posedge clk); #1;
    check("up_drained", up_q.size(), 0);

    // Reset mid-operation on a full OOB FIFO.
    pulse_clr();
    co_ready = 1'b0;
    send_oob(SOP, 32'hB0B0_0001);
    send_oob(MOP, 32'hB0B0_0002);
    @(negedge clk);
    check("oob_full_valid", co_valid, 1);
    check("oob_full_ready", oob_ready, 0);
    #2 reset_poweron = 1'b0;
    #1;
    check("oob_rst_valid", co_valid, 0);
    check("oob_rst_ready", oob_ready, 1);
    check("oob_rst_err", oob_err, 0);
    repeat (2) @(posedge clk);
    @(negedge clk) reset_poweron = 1'b1;
    co_ready = 1'b1;
    @(posedge clk); #1;
    send_oob(EOP, 32'hB0B0_0003);
    check("oob_err_after_rst", oob_err, 1);
    repeat (4) @(posedge clk); #1;
    check("oob_drained", oob_q.size(), 0);
    check("oob_valid_idle", co_valid, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
